// File: rtl/mips_cp0_pkg.sv
// CP0 register numbers, exception codes and Status/Cause bit positions.
// Shared by the exception sink and its optional timer.
package mips_cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_BD     = 31;
  localparam int CA_IP_LO  = 8;
  localparam int CA_EXC_LO = 2;

  // Software-visible write masks: Status IE/EXL/IM, Cause IP[1:0] only.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with a sticky match flag; Count free-runs every clock.
// A Compare write clears the flag; a Count write still lets a same-cycle match set it.
module cp0_timer
  import mips_cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_flag
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      compare    <= '0;
      timer_flag <= 1'b0;
    end else begin
      count <= we_count ? wdata : count + 32'd1;
      if (we_compare) begin
        compare    <= wdata;
        timer_flag <= 1'b0;
      end else if (count == compare) begin
        timer_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception sink: records Status/Cause/EPC and pulses a registered redirect.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_unit
  import mips_cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
  parameter int          HW_INT_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exp_overflow,
  input  logic                exp_syscall,
  input  logic                exp_ri,
  input  logic                eret,
  input  logic                instr_valid,
  input  logic [31:0]         ex_pc,
  input  logic                ex_in_ds,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                cp0_we,
  input  logic [4:0]          cp0_waddr,
  input  logic [31:0]         cp0_wdata,
  input  logic [4:0]          cp0_raddr,
  output logic [31:0]         cp0_rdata,
  output logic                redirect,
  output logic [31:0]         redirect_pc,
  output logic [31:0]         status_o
);

  logic [31:0]         status, cause, epc;
  logic [31:0]         count, compare;
  logic [HW_INT_W-1:0] ip_hw;
  logic                int_pend, exc, eret_take, mtc0;
  logic [4:0]          exc_code;

`ifdef CP0_TIMER_EN
  logic timer_flag;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .we_count   (mtc0 && cp0_waddr == CP0_COUNT),
    .we_compare (mtc0 && cp0_waddr == CP0_COMPARE),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_flag (timer_flag)
  );

  assign ip_hw = {hw_int[HW_INT_W-1] | timer_flag, hw_int[HW_INT_W-2:0]};
`else
  assign count   = '0;
  assign compare = '0;
  assign ip_hw   = hw_int;
`endif

  assign int_pend = (|(cause[CA_IP_LO +: 8] & status[ST_IM_LO +: 8])) &
                    status[ST_IE] & ~status[ST_EXL] & instr_valid;

  always_comb begin
    exc      = 1'b1;
    exc_code = EXC_INT;
    if (int_pend)                         exc_code = EXC_INT;
    else if (instr_valid && exp_ri)       exc_code = EXC_RI;
    else if (instr_valid && exp_overflow) exc_code = EXC_OV;
    else if (instr_valid && exp_syscall)  exc_code = EXC_SYS;
    else                                  exc      = 1'b0;
  end

  assign eret_take = eret & ~exc;
  assign mtc0      = cp0_we & ~exc & ~eret_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status      <= '0;
      cause       <= '0;
      epc         <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      cause[CA_IP_LO+2 +: HW_INT_W] <= ip_hw;
      redirect <= exc | eret_take;
      if (exc) begin
        cause[CA_EXC_LO +: 5] <= exc_code;
        // A nested exception keeps the original return point.
        if (!status[ST_EXL]) begin
          epc          <= ex_in_ds ? ex_pc - 32'd4 : ex_pc;
          cause[CA_BD] <= ex_in_ds;
        end
        status[ST_EXL] <= 1'b1;
        redirect_pc    <= EXC_VECTOR;
      end else if (eret_take) begin
        status[ST_EXL] <= 1'b0;
        redirect_pc    <= epc;
      end else if (mtc0) begin
        case (cp0_waddr)
          CP0_STATUS: status <= cp0_wdata & STATUS_WMASK;
          CP0_CAUSE:  cause[CA_IP_LO +: 2] <= cp0_wdata[CA_IP_LO +: 2];
          CP0_EPC:    epc <= cp0_wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      CP0_STATUS:  cp0_rdata = status;
      CP0_CAUSE:   cp0_rdata = cause;
      CP0_EPC:     cp0_rdata = epc;
      CP0_COUNT:   cp0_rdata = count;
      CP0_COMPARE: cp0_rdata = compare;
      default:     cp0_rdata = '0;
    endcase
  end

  assign status_o = status;

endmodule
